// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the encoder -> error channel -> Viterbi decoder chain.
// Streams a latched message plus zero tail bits into the encoder, drives a
// periodic per-symbol flip mask into the channel, captures the decoded bits
// and reports the recovered message, bit errors and injected symbol count.
module viterbi_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned TAIL_LEN  = 2,
  parameter int unsigned DEC_LAT   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic [FRAME_LEN-1:0]             msg_i,
  input  logic [3:0]                       err_period_i,
  input  logic [1:0]                       err_mask_i,
  output logic                             busy_o,
  output logic                             enc_en_o,
  output logic                             enc_d_o,
  output logic [1:0]                       chan_flip_o,
  output logic                             dec_en_o,
  input  logic                             dec_d_i,
  output logic                             done_o,
  output logic [FRAME_LEN-1:0]             rx_msg_o,
  output logic [$clog2(FRAME_LEN+1)-1:0]   bit_err_o,
  output logic [7:0]                       inj_ct_o
);

  localparam int unsigned SymN = FRAME_LEN + TAIL_LEN;
  localparam int unsigned SymW = $clog2(SymN + 1);
  localparam int unsigned CycW = $clog2(DEC_LAT + 2);
  localparam int unsigned CapW = $clog2(FRAME_LEN + 1);
  localparam int unsigned BW   = $clog2(FRAME_LEN + 1);

  typedef enum logic [2:0] {StIdle, StSend, StTail, StDrain, StDone} state_e;

  state_e               r_state, w_state_d;
  logic [FRAME_LEN-1:0] r_tx, r_msg, r_rx, r_rx_out;
  logic [3:0]           r_period, r_phase;
  logic [1:0]           r_mask, r_flip;
  logic [SymW-1:0]      r_sym;
  logic [CycW-1:0]      r_cyc;
  logic [CapW-1:0]      r_cap;
  logic [7:0]           r_inj, r_inj_out;
  logic [BW-1:0]        r_berr_out;
  logic                 r_dec_en;

  logic                 w_enc_en, w_enc_d, w_start_acc, w_to_done, w_run;
  logic                 w_hit, w_cap_fire, w_cap_last;
  logic [1:0]           w_flip_d;
  logic [FRAME_LEN-1:0] w_rx_d, w_rx_fin;
  logic [BW-1:0]        w_berr;

  // Frame-relative cycle counter saturates once the capture window opens.
  assign w_run      = (r_state == StSend) || (r_state == StTail) || (r_state == StDrain);
  assign w_cap_fire = w_run && (r_cyc == CycW'(DEC_LAT + 1)) && (r_cap < CapW'(FRAME_LEN));
  assign w_cap_last = w_cap_fire && (r_cap == CapW'(FRAME_LEN - 1));
  assign w_rx_d     = {r_rx[FRAME_LEN-2:0], dec_d_i};
  assign w_rx_fin   = w_cap_fire ? w_rx_d : r_rx;

  // Injection fires on the last symbol of each period window.
  assign w_hit    = (r_period != 4'd0) && (r_phase == (r_period - 4'd1));
  assign w_flip_d = (w_enc_en && w_hit) ? r_mask : 2'b00;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // Next-state decode and encoder-side outputs.
  always_comb begin
    w_state_d   = r_state;
    w_enc_en    = 1'b0;
    w_enc_d     = 1'b0;
    w_start_acc = 1'b0;
    w_to_done   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_start_acc = 1'b1;
          w_state_d   = StSend;
        end
      end
      StSend: begin
        w_enc_en = 1'b1;
        w_enc_d  = r_tx[FRAME_LEN-1];
        if (r_sym == SymW'(FRAME_LEN - 1)) w_state_d = (TAIL_LEN == 0) ? StDrain : StTail;
      end
      StTail: begin
        w_enc_en = 1'b1;
        if (r_sym == SymW'(SymN - 1)) w_state_d = StDrain;
      end
      StDrain: begin
        // Short decoder latency can finish capturing before DRAIN is reached.
        if (w_cap_last || (r_cap == CapW'(FRAME_LEN))) begin
          w_to_done = 1'b1;
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Bit-error popcount over the completed capture.
  always_comb begin
    w_berr = '0;
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      w_berr = w_berr + BW'(w_rx_fin[i] ^ r_msg[i]);
    end
  end

  // Datapath: latching, symbol sequencing, flip generation, capture, results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx       <= '0;
      r_msg      <= '0;
      r_period   <= '0;
      r_mask     <= '0;
      r_sym      <= '0;
      r_phase    <= '0;
      r_cyc      <= '0;
      r_cap      <= '0;
      r_rx       <= '0;
      r_inj      <= '0;
      r_dec_en   <= 1'b0;
      r_flip     <= '0;
      r_rx_out   <= '0;
      r_berr_out <= '0;
      r_inj_out  <= '0;
    end else begin
      r_dec_en <= w_enc_en;
      r_flip   <= w_flip_d;
      if (w_start_acc) begin
        r_tx     <= msg_i;
        r_msg    <= msg_i;
        r_period <= err_period_i;
        r_mask   <= err_mask_i;
        r_sym    <= '0;
        r_phase  <= '0;
        r_cyc    <= '0;
        r_cap    <= '0;
        r_rx     <= '0;
        r_inj    <= '0;
      end else begin
        if (w_enc_en) begin
          r_sym   <= r_sym + SymW'(1);
          r_phase <= w_hit ? 4'd0 : r_phase + 4'd1;
          if (r_state == StSend) r_tx <= {r_tx[FRAME_LEN-2:0], 1'b0};
        end
        if (w_run && (r_cyc != CycW'(DEC_LAT + 1))) r_cyc <= r_cyc + CycW'(1);
        if (w_cap_fire) begin
          r_rx  <= w_rx_d;
          r_cap <= r_cap + CapW'(1);
        end
        if ((w_flip_d != 2'b00) && (r_inj != 8'hFF)) r_inj <= r_inj + 8'd1;
      end
      if (w_to_done) begin
        r_rx_out   <= w_rx_fin;
        r_berr_out <= w_berr;
        r_inj_out  <= r_inj;
      end
    end
  end

  assign busy_o      = (r_state != StIdle);
  assign done_o      = (r_state == StDone);
  assign enc_en_o    = w_enc_en;
  assign enc_d_o     = w_enc_d;
  assign dec_en_o    = r_dec_en;
  assign chan_flip_o = r_flip;
  assign rx_msg_o    = r_rx_out;
  assign bit_err_o   = r_berr_out;
  assign inj_ct_o    = r_inj_out;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl: a loopback channel model returns
// the encoder stream delayed by 1+DEC_LAT (with optional per-bit inversion),
// stimulus pushes hand-computed expectations, a negedge monitor checks them.
module tb_viterbi_frame_ctrl;

  localparam int FL = 16;
  localparam int TL = 2;
  localparam int DL = 8;
  localparam int NS = FL + TL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] msg_i = '0;
  logic [3:0]  err_period_i = '0;
  logic [1:0]  err_mask_i = '0;
  logic        busy_o, enc_en_o, enc_d_o, dec_en_o, dec_d_i, done_o;
  logic [1:0]  chan_flip_o;
  logic [15:0] rx_msg_o;
  logic [4:0]  bit_err_o;
  logic [7:0]  inj_ct_o;

  always #5 clk = ~clk;

  viterbi_frame_ctrl #(.FRAME_LEN(FL), .TAIL_LEN(TL), .DEC_LAT(DL)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .msg_i        (msg_i),
    .err_period_i (err_period_i),
    .err_mask_i   (err_mask_i),
    .busy_o       (busy_o),
    .enc_en_o     (enc_en_o),
    .enc_d_o      (enc_d_o),
    .chan_flip_o  (chan_flip_o),
    .dec_en_o     (dec_en_o),
    .dec_d_i      (dec_d_i),
    .done_o       (done_o),
    .rx_msg_o     (rx_msg_o),
    .bit_err_o    (bit_err_o),
    .inj_ct_o     (inj_ct_o)
  );

  // Loopback decoder model: decoded bit k = encoder bit k (xor inv_k[k]), 1+DL cycles later.
  logic [15:0] dly = '0;
  logic [15:0] invl = '0;
  logic [15:0] inv_k = '0;
  int          enc_idx = 0;
  always @(posedge clk) begin
    dly <= {dly[14:0], enc_d_o};
    if (enc_en_o) begin
      invl    <= {invl[14:0], (enc_idx < FL) ? inv_k[enc_idx] : 1'b0};
      enc_idx <= enc_idx + 1;
    end else begin
      invl    <= {invl[14:0], 1'b0};
      enc_idx <= 0;
    end
  end
  assign dec_d_i = dly[DL] ^ invl[DL];

  typedef struct {
    logic [15:0] rx;
    logic [4:0]  berr;
    logic [7:0]  inj;
    logic [17:0] enc_bits;
    logic [17:0] flip_pos;
    logic [1:0]  flip_or;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   tmo_n = 0;
  logic zero_req = 1'b0;
  logic idle_req = 1'b0;
  logic final_req = 1'b0;

  // Monitor state
  int          cyc = 0;
  int          t_start, t_dec, enc_n, dec_n, stray, dones = 0;
  logic [17:0] enc_bits, flip_pos;
  logic [1:0]  flip_or;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic clr_acc();
    t_start = 0; t_dec = 0; enc_n = 0; dec_n = 0; stray = 0;
    enc_bits = '0; flip_pos = '0; flip_or = '0;
  endtask

  // Monitor: sole owner of the check counters.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (zero_req)
      chk("outputs_zero", {busy_o, enc_en_o, enc_d_o, chan_flip_o, dec_en_o, done_o,
                           rx_msg_o, bit_err_o, inj_ct_o}, '0);
    if (idle_req) chk("idle_no_frame", {busy_o, enc_en_o}, '0);
    if (rst) begin
      clr_acc();
    end else begin
      if (enc_en_o) begin
        if (enc_n == 0) t_start = cyc;
        enc_bits = {enc_bits[16:0], enc_d_o};
        enc_n++;
      end
      if (dec_en_o) begin
        if (dec_n == 0) t_dec = cyc;
        if (chan_flip_o != 2'b00 && dec_n < NS) flip_pos[dec_n] = 1'b1;
        flip_or = flip_or | chan_flip_o;
        dec_n++;
      end else if (chan_flip_o != 2'b00) begin
        stray++;
      end
      if (done_o) begin
        dones++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rx_msg", rx_msg_o, e.rx);
          chk("bit_err", bit_err_o, e.berr);
          chk("inj_ct", inj_ct_o, e.inj);
          chk("enc_bits", enc_bits, e.enc_bits);
          chk("enc_en_cycles", enc_n, NS);
          chk("dec_en_cycles", dec_n, NS);
          chk("dec_en_offset", t_dec - t_start, 1);
          chk("flip_positions", flip_pos, e.flip_pos);
          chk("flip_value", flip_or, e.flip_or);
          chk("flip_outside_dec_en", stray, 0);
          chk("done_latency", cyc - t_start, 1 + DL + FL);
        end
        clr_acc();
      end
    end
    if (final_req) begin
      chk("scoreboard_empty", sb.size(), 0);
      chk("done_count", dones, 7);
      chk("timeouts", tmo_n, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || done_o) && n < 200) begin tick(); n++; end
    if (busy_o || done_o) tmo_n++;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 200) begin tick(); n++; end
    if (!done_o) tmo_n++;
  endtask

  // Hand-computed rx/berr/inj; stream and flip positions follow from msg/period.
  task automatic push_exp(input logic [15:0] msg, input int per, input logic [1:0] mask,
                          input logic [15:0] rx, input logic [4:0] berr, input logic [7:0] inj);
    exp_t e;
    e.rx = rx; e.berr = berr; e.inj = inj;
    e.enc_bits = {msg, 2'b00};
    e.flip_pos = '0;
    for (int s = 0; s < NS; s++)
      if (per != 0 && mask != 2'b00 && (s % per) == per - 1) e.flip_pos[s] = 1'b1;
    e.flip_or = (e.flip_pos != '0) ? mask : 2'b00;
    sb.push_back(e);
  endtask

  task automatic start_frame(input logic [15:0] msg, input int per, input logic [1:0] mask,
                             input logic [15:0] inv, input bit hold, input logic [15:0] rx,
                             input logic [4:0] berr, input logic [7:0] inj);
    wait_idle();
    push_exp(msg, per, mask, rx, berr, inj);
    inv_k = inv; msg_i = msg; err_period_i = 4'(per); err_mask_i = mask;
    start_i = 1'b1;
    tick();
    if (!hold) start_i = 1'b0;
  endtask

  initial begin
    // Reset held 3 cycles with start asserted.
    rst = 1'b1; start_i = 1'b1;
    tick();
    zero_req = 1'b1;
    tick(); tick();
    rst = 1'b0; start_i = 1'b0;
    tick();
    zero_req = 1'b0;

    // Clean loopback
    start_frame(16'hA5C3, 0, 2'b00, 16'h0000, 0, 16'hA5C3, 5'd0, 8'd0);
    wait_done();
    // Period 4, both bits flipped
    start_frame(16'h0000, 4, 2'b11, 16'h0000, 0, 16'h0000, 5'd0, 8'd4);
    wait_done();
    // Period 1 with start held through the whole frame
    start_frame(16'h0000, 1, 2'b01, 16'h0000, 1, 16'h0000, 5'd0, 8'd18);
    wait_done();
    start_i = 1'b0;
    tick();
    idle_req = 1'b1;
    repeat (6) tick();
    idle_req = 1'b0;
    // Decoder errors on k=0 and k=5
    start_frame(16'hFFFF, 0, 2'b00, 16'h0021, 0, 16'h7BFF, 5'd2, 8'd0);
    wait_done();

    // Start in DONE is ignored; start in the following IDLE cycle is taken.
    start_frame(16'h1111, 0, 2'b00, 16'h0000, 0, 16'h1111, 5'd0, 8'd0);
    wait_done();
    msg_i = 16'h5555; err_period_i = 4'd4; err_mask_i = 2'b01; start_i = 1'b1;
    tick();
    push_exp(16'h3C3C, 2, 2'b10, 16'h3C3C, 5'd0, 8'd9);
    inv_k = 16'h0000; msg_i = 16'h3C3C; err_period_i = 4'd2; err_mask_i = 2'b10;
    tick();
    start_i = 1'b0;
    wait_done();

    // Reset during SEND symbol 7
    wait_idle();
    msg_i = 16'hBEEF; err_period_i = 4'd3; err_mask_i = 2'b11; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    zero_req = 1'b1;
    tick();
    zero_req = 1'b0;
    start_frame(16'h1234, 0, 2'b00, 16'h0000, 0, 16'h1234, 5'd0, 8'd0);
    wait_done();

    tick();
    final_req = 1'b1;
    tick();
    final_req = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
Frame-level sequencer for the convolutional encoder, error-injecting channel and Viterbi decoder chain.
- On a start request it latches a FRAME_LEN-bit message and streams it serially into the encoder, followed by TAIL_LEN zero flush bits.
- It drives per-symbol channel bit-flip controls from a programmable error period, and gates the decoder enable.
- It captures the decoded bits, then reports the recovered message, the bit-error count and the number of injected symbol errors.

Parameters:
FRAME_LEN, 16, message bits per frame (>=2)
TAIL_LEN, 2, zero flush bits after message (K-1 of encoder)
DEC_LAT, 8, cycles from dec_en_o high for symbol k to decoded bit k valid on dec_d_i (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start_i  in  1  frame start request, honoured only in IDLE
msg_i  in  FRAME_LEN  message, sent MSB first, latched on accepted start
err_period_i  in  4  injection period in symbols; 0 = no injection; latched on start
err_mask_i  in  2  which symbol bits to flip on an injection symbol; latched on start
busy_o  out  1  high from the cycle after start acceptance through the DONE cycle
enc_en_o  out  1  encoder enable
enc_d_o  out  1  encoder serial data input
chan_flip_o  out  2  channel flip mask, aligned with the encoder output symbol (one cycle after enc_en_o)
dec_en_o  out  1  decoder enable
dec_d_i  in  1  decoder serial output
done_o  out  1  one-cycle pulse; results valid from this cycle
rx_msg_o  out  FRAME_LEN  captured decoded message, held until next done
bit_err_o  out  $clog2(FRAME_LEN+1)  popcount(rx_msg_o ^ latched msg)
inj_ct_o  out  8  symbols flipped in the last frame (saturating at 255)

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters, latched message and results cleared. Reset takes effect mid-frame with no drain.
- States: IDLE, SEND, TAIL, DRAIN, DONE.
- IDLE: start_i=1 latches msg_i, err_period_i and err_mask_i, and clears the symbol index, capture index and inj counter; next state is SEND.
- start_i is ignored in all other states, including DONE.
- SEND, FRAME_LEN cycles: enc_en_o=1; enc_d_o=msg[FRAME_LEN-1-i] for i=0..FRAME_LEN-1; then go to TAIL.
- TAIL, TAIL_LEN cycles: enc_en_o=1, enc_d_o=0; then go to DRAIN.
- Symbol index s runs 0..FRAME_LEN+TAIL_LEN-1 across SEND and TAIL.
- dec_en_o = enc_en_o delayed by one register, matching the encoder's registered output.
- chan_flip_o = err_mask when period!=0 and s mod period == period-1; otherwise 0.
  - It is registered, so it is asserted the cycle after the encoder input for symbol s, coincident with dec_en_o.
  - inj_ct increments for each symbol where chan_flip_o != 0.
- Capture: dec_d_i is sampled at t0+1+DEC_LAT+k for k=0..FRAME_LEN-1, where t0 = first SEND cycle.
  - Sampled bits are shifted into rx_msg MSB first.
  - The tail bits' decoded outputs are not captured.
  - Capture runs through SEND, TAIL and DRAIN as timing requires, using a free-running cycle counter started at t0.
- DRAIN: waits until the last capture (k=FRAME_LEN-1), then goes to DONE the next cycle.
- DONE, one cycle: done_o=1; rx_msg_o, bit_err_o and inj_ct_o are updated from internal registers in this cycle, the same cycle done_o is high. Next state is IDLE.
- busy_o=0 in IDLE only.
- Outputs enc_en_o, enc_d_o, dec_en_o and chan_flip_o are 0 outside their active windows.

Test Plan:
- Reset: hold rst=1 for 3 cycles with start_i=1 -> all outputs 0, no enc_en_o.
- Clean loopback: bench returns dec_d_i = enc_d_o delayed 1+DEC_LAT. start with msg=16'hA5C3, period=0.
  - enc_en_o high 18 cycles; enc_d_o = 1010010111000011 then 00.
  - dec_en_o high 18 cycles, one cycle later.
  - done_o at t0+1+8+16=t0+25; rx_msg_o=16'hA5C3, bit_err_o=0, inj_ct_o=0.
- Injection: period=4, mask=2'b11, msg=16'h0000 -> chan_flip_o=11 at s=3,7,11,15 only; inj_ct_o=4. Period=1, mask=01 -> flip every symbol; inj_ct_o=18.
- Decoder errors: loopback with bits k=0 and k=5 inverted, msg=16'hFFFF -> rx_msg_o=16'h7BFF, bit_err_o=2.
- Start handling:
  - start_i held high through the frame -> exactly one frame runs.
  - start_i high in the DONE cycle is ignored; start_i high in the following IDLE cycle begins the next frame, and its results replace the previous ones at the next done_o.
- Mid-frame reset: rst=1 at SEND symbol 7 -> next cycle all outputs 0, state IDLE; a following start with msg=16'h1234 completes cleanly with bit_err_o=0.
